regfile_read_arbiter: RTL

- Shares one 32-entry register-file read port among NREQ requesters, e.g. decode operand A, decode operand B, and a debug/store-data port.
- The read port is built from ThirtyTwoMux instances with a common 5-bit select.
- Sits between the requesters and the mux bank. Arbitrates round-robin, drives a registered mux select, captures the mux output, and returns tagged read data to the winning requester.

---
 rtl/regfile_read_arbiter_if.sv | 25 ++
 rtl/regfile_read_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/regfile_read_arbiter_if.sv
// Requester / mux-bank side bundle of the shared register-file read port.
// The arbiter owns the slave view; the requesters plus mux bank own the master view.
interface regfile_read_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32
);
   logic [NREQ-1:0]   req;
   logic [NREQ*5-1:0] req_addr;
   logic [NREQ-1:0]   gnt;
   logic [4:0]        mux_sel;
   logic [WIDTH-1:0]  mux_data;
   logic [NREQ-1:0]   rd_valid;
   logic [WIDTH-1:0]  rd_data;
   logic              busy;

   modport slave (
      input  req, req_addr, mux_data,
      output gnt, mux_sel, rd_valid, rd_data, busy
   );

   modport master (
      output req, req_addr, mux_data,
      input  gnt, mux_sel, rd_valid, rd_data, busy
   );
endinterface

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter in front of a shared 32-entry register-file read port.
// Grant in cycle t -> registered mux select in t+1 -> tagged read data in t+2.
module regfile_read_arbiter #(
   parameter int NREQ     = 4,
   parameter int WIDTH    = 32,
   parameter int ZERO_REG = 1
) (
   input logic                   clk,
   input logic                   reset,
   regfile_read_arbiter_if.slave bus
);
   localparam int              PW      = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [NREQ-1:0] ONE     = NREQ'(1);
   localparam bit              ZERO_EN = (ZERO_REG != 0);

   logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [4:0]       mux_sel_q;
   logic             s1_valid_q;
   logic [PW-1:0]    s1_tag_q;
   logic             s1_zero_q;
   logic [NREQ-1:0]  rd_valid_q;
   logic [WIDTH-1:0] rd_data_q;

   logic [NREQ-1:0]  gnt_d;
   logic             grant_any;
   logic [PW-1:0]    win_idx;
   logic [4:0]       win_addr;

   // Round-robin search from rr_ptr upward with wrap; first requester found wins.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      gnt_d     = '0;
      grant_any = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (!grant_any && bus.req[(int'(rr_ptr_q) + k) % NREQ]) begin
            grant_any = 1'b1;
            win_idx   = PW'((int'(rr_ptr_q) + k) % NREQ);
         end
      end
      // Grants are suppressed while reset is held.
      if (!reset) begin
         grant_any = 1'b0;
      end
      if (grant_any) begin
         gnt_d[win_idx] = 1'b1;
      end
   end

   // Winner's address and the pointer value that follows it.
   always_comb begin
      win_addr = bus.req_addr[int'(win_idx)*5 +: 5];
      rr_ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
   end

   // Pointer, stage-1 select/tag and stage-2 read-data pipeline with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) begin
         rr_ptr_q   <= '0;
         mux_sel_q  <= '0;
         s1_valid_q <= 1'b0;
         s1_tag_q   <= '0;
         s1_zero_q  <= 1'b0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
      end else begin
         if (grant_any) begin
            rr_ptr_q  <= rr_ptr_d;
            mux_sel_q <= win_addr;
            s1_tag_q  <= win_idx;
            s1_zero_q <= ZERO_EN && (win_addr == 5'd31);
         end
         s1_valid_q <= grant_any;
         rd_valid_q <= s1_valid_q ? (ONE << s1_tag_q) : '0;
         // Data holds between reads; the zero register never exposes the mux output.
         if (s1_valid_q) begin
            rd_data_q <= s1_zero_q ? '0 : bus.mux_data;
         end
      end
   end

   assign bus.gnt      = gnt_d;
   assign bus.mux_sel  = mux_sel_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.busy     = (|bus.req) | s1_valid_q | (|rd_valid_q);

endmodule
